retire_trace_tx: RTL and testbench

Commit-trace transmitter inside Top, fed by the write-back stage. Packages each retired instruction into a trace record, buffers records in a small FIFO, and sends them over a valid/ready port to the lockstep checker (DPI compare_r/i/j). Also detects end-of-test: syscall (instr 0x0000000c) with $v0 == 0xa.

---
 rtl/retire_trace_tx.sv | 207 ++++++++++++++++++++
 tb/tb_retire_trace_tx.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/retire_trace_tx.sv
// Commit-trace transmitter: classifies retiring instructions into trace records, buffers them in a FWFT FIFO
// and streams them out over valid/ready. Optional build macro TRACE_TIMESTAMP_EN adds a per-record cycle stamp.
module retire_trace_tx #(
   parameter int DEPTH = 4,
   parameter int XLEN  = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            wb_valid,
   input  logic [XLEN-1:0] wb_pc,
   input  logic [31:0]     wb_instr,
   input  logic            wb_reg_write,
   input  logic [XLEN-1:0] wb_data,
   input  logic [XLEN-1:0] wb_rs_val,
   input  logic [XLEN-1:0] wb_rt_val,
   input  logic [XLEN-1:0] wb_v0_val,
   output logic            trace_valid,
   input  logic            trace_ready,
   output logic [XLEN-1:0] trace_pc,
   output logic [31:0]     trace_instr,
   output logic [1:0]      trace_kind,
   output logic [4:0]      trace_dest,
   output logic [XLEN-1:0] trace_dest_val,
   output logic [XLEN-1:0] trace_rs_val,
   output logic [XLEN-1:0] trace_rt_val,
   output logic            stall_req,
   output logic            overflow,
   output logic            test_done,
   output logic [31:0]     retired_count
`ifdef TRACE_TIMESTAMP_EN
   ,
   output logic [31:0]     trace_cycle
`endif
);

   // state | meaning
   // RUN   | normal tracing, captures accepted
   // DRAIN | end-of-test syscall queued, captures ignored until FIFO empties
   // DONE  | FIFO drained, test_done held until reset
   typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_DONE} state_t;

   localparam int            AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
   localparam logic [1:0]    KIND_R   = 2'd0;
   localparam logic [1:0]    KIND_I   = 2'd1;
   localparam logic [1:0]    KIND_J   = 2'd2;
   localparam logic [1:0]    KIND_SYS = 2'd3;

   state_t          state_q, state_d;
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [AW:0]     cnt_q, cnt_d;
   logic            overflow_q, overflow_d;
   logic [31:0]     retired_q, retired_d;

   logic [XLEN-1:0] pc_mem    [DEPTH];
   logic [31:0]     instr_mem [DEPTH];
   logic [1:0]      kind_mem  [DEPTH];
   logic [4:0]      dest_mem  [DEPTH];
   logic [XLEN-1:0] dval_mem  [DEPTH];
   logic [XLEN-1:0] rs_mem    [DEPTH];
   logic [XLEN-1:0] rt_mem    [DEPTH];

   logic [5:0]      opcode;
   logic [5:0]      funct;
   logic [1:0]      kind_c;
   logic [4:0]      dest_c;
   logic [XLEN-1:0] dval_c;
   logic            capture, push, pop, full, empty, end_hit;

   assign opcode = wb_instr[31:26];
   assign funct  = wb_instr[5:0];

   always_comb begin
      kind_c = KIND_I;
      dest_c = wb_instr[20:16];
      if (opcode == 6'd0) begin
         if (funct == 6'h0c) begin
            kind_c = KIND_SYS;
            dest_c = 5'd0;
         end else begin
            kind_c = KIND_R;
            dest_c = wb_instr[15:11];
         end
      end else if (opcode == 6'd2) begin
         kind_c = KIND_J;
         dest_c = 5'd0;
      end else if (opcode == 6'd3) begin
         kind_c = KIND_J;
         dest_c = 5'd31;
      end
   end

   // Without a write-back the record carries the register's current value where the bench knows it (rt for I-type).
   always_comb begin
      dval_c = '0;
      if (wb_reg_write) begin
         dval_c = wb_data;
      end else if (kind_c == KIND_I) begin
         dval_c = wb_rt_val;
      end
   end

   assign empty       = (cnt_q == '0);
   assign full        = (cnt_q == FULL_CNT);
   assign trace_valid = !empty && (state_q != ST_DONE);
   assign pop         = trace_valid && trace_ready;
   assign capture     = wb_valid && (wb_instr != 32'd0) && (state_q == ST_RUN);
   assign push        = capture && (!full || pop);
   assign end_hit     = push && (kind_c == KIND_SYS) && (wb_v0_val == XLEN'(32'h0000_000a));

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      cnt_d      = cnt_q;
      retired_d  = retired_q;
      overflow_d = overflow_q | (capture && full && !pop);
      if (push) begin
         wr_ptr_d  = wr_ptr_q + AW'(1);
         retired_d = retired_q + 32'd1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      if (push && !pop) begin
         cnt_d = cnt_q + (AW+1)'(1);
      end else if (pop && !push) begin
         cnt_d = cnt_q - (AW+1)'(1);
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_RUN:   if (end_hit) state_d = ST_DRAIN;
         ST_DRAIN: if (empty)   state_d = ST_DONE;
         ST_DONE:  state_d = ST_DONE;
         default:  state_d = ST_RUN;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_RUN;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         cnt_q      <= '0;
         overflow_q <= 1'b0;
         retired_q  <= '0;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         cnt_q      <= cnt_d;
         overflow_q <= overflow_d;
         retired_q  <= retired_d;
      end
   end

   // Payload storage needs no reset: outputs are masked whenever no valid head exists.
   always_ff @(posedge clk) begin
      if (push) begin
         pc_mem[wr_ptr_q]    <= wb_pc;
         instr_mem[wr_ptr_q] <= wb_instr;
         kind_mem[wr_ptr_q]  <= kind_c;
         dest_mem[wr_ptr_q]  <= dest_c;
         dval_mem[wr_ptr_q]  <= dval_c;
         rs_mem[wr_ptr_q]    <= wb_rs_val;
         rt_mem[wr_ptr_q]    <= wb_rt_val;
      end
   end

   assign trace_pc       = trace_valid ? pc_mem[rd_ptr_q]    : '0;
   assign trace_instr    = trace_valid ? instr_mem[rd_ptr_q] : '0;
   assign trace_kind     = trace_valid ? kind_mem[rd_ptr_q]  : '0;
   assign trace_dest     = trace_valid ? dest_mem[rd_ptr_q]  : '0;
   assign trace_dest_val = trace_valid ? dval_mem[rd_ptr_q]  : '0;
   assign trace_rs_val   = trace_valid ? rs_mem[rd_ptr_q]    : '0;
   assign trace_rt_val   = trace_valid ? rt_mem[rd_ptr_q]    : '0;

   assign stall_req     = full;
   assign overflow      = overflow_q;
   assign test_done     = (state_q == ST_DONE);
   assign retired_count = retired_q;

`ifdef TRACE_TIMESTAMP_EN
   logic [31:0] cycle_q;
   logic [31:0] cyc_mem [DEPTH];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cycle_q <= '0;
      end else begin
         cycle_q <= cycle_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         cyc_mem[wr_ptr_q] <= cycle_q;
      end
   end

   assign trace_cycle = trace_valid ? cyc_mem[rd_ptr_q] : '0;
`endif

endmodule

// File: tb/tb_retire_trace_tx.sv
// Scoreboard bench for retire_trace_tx: expected records are queued at drive time and popped on each handshake.
module tb_retire_trace_tx;

   logic        clk = 1'b0;
   logic        reset;
   logic        wb_valid;
   logic [31:0] wb_pc, wb_instr, wb_data, wb_rs_val, wb_rt_val, wb_v0_val;
   logic        wb_reg_write;
   logic        trace_valid, trace_ready;
   logic [31:0] trace_pc, trace_instr, trace_dest_val, trace_rs_val, trace_rt_val;
   logic [1:0]  trace_kind;
   logic [4:0]  trace_dest;
   logic        stall_req, overflow, test_done;
   logic [31:0] retired_count;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
      logic [1:0]  kind;
      logic [4:0]  dest;
      logic [31:0] dval;
      logic [31:0] rs;
      logic [31:0] rt;
   } rec_t;

   rec_t exp_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   exp_retired = 0;

   retire_trace_tx #(.DEPTH(4), .XLEN(32)) dut (
      .clk(clk), .reset(reset),
      .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_instr(wb_instr), .wb_reg_write(wb_reg_write),
      .wb_data(wb_data), .wb_rs_val(wb_rs_val), .wb_rt_val(wb_rt_val), .wb_v0_val(wb_v0_val),
      .trace_valid(trace_valid), .trace_ready(trace_ready),
      .trace_pc(trace_pc), .trace_instr(trace_instr), .trace_kind(trace_kind), .trace_dest(trace_dest),
      .trace_dest_val(trace_dest_val), .trace_rs_val(trace_rs_val), .trace_rt_val(trace_rt_val),
      .stall_req(stall_req), .overflow(overflow), .test_done(test_done), .retired_count(retired_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!reset && trace_valid && trace_ready) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_record", 64'd1, 64'd0);
         end else begin
            rec_t e;
            e = exp_q.pop_front();
            chk("rec_pc",    trace_pc,       e.pc);
            chk("rec_instr", trace_instr,    e.instr);
            chk("rec_kind",  trace_kind,     e.kind);
            chk("rec_dest",  trace_dest,     e.dest);
            chk("rec_dval",  trace_dest_val, e.dval);
            chk("rec_rs",    trace_rs_val,   e.rs);
            chk("rec_rt",    trace_rt_val,   e.rt);
         end
      end
   end

   task automatic wb_pulse(input logic [31:0] pc, input logic [31:0] instr, input logic rw,
                           input logic [31:0] data, input logic [31:0] rs, input logic [31:0] rt,
                           input logic [31:0] v0, input logic acc, input logic [1:0] k,
                           input logic [4:0] d, input logic [31:0] dv);
      rec_t r;
      wb_valid = 1'b1; wb_pc = pc; wb_instr = instr; wb_reg_write = rw;
      wb_data = data; wb_rs_val = rs; wb_rt_val = rt; wb_v0_val = v0;
      if (acc) begin
         r = '{pc, instr, k, d, dv, rs, rt};
         exp_q.push_back(r);
         exp_retired++;
      end
      @(posedge clk); #1;
      wb_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      exp_q.delete();
      exp_retired = 0;
      @(posedge clk); #1;
      reset = 1'b0;
   endtask

   task automatic wait_drain(input int max_cycles);
      int i = 0;
      while (exp_q.size() != 0 && i < max_cycles) begin
         @(posedge clk); #1;
         i++;
      end
      chk("drain_timeout", 64'(exp_q.size()), 64'd0);
   endtask

   task automatic push_i(input int idx, input logic acc);
      wb_pulse(32'h1000 + 32'(idx) * 4, 32'h2109_0000 | 32'(idx + 1), 1'b1, 32'h200 + 32'(idx),
               32'h11, 32'h77, 32'h0, acc, 2'd1, 5'd9, 32'h200 + 32'(idx));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int w;
      reset = 1'b1; trace_ready = 1'b0; wb_valid = 1'b0; wb_reg_write = 1'b0;
      wb_pc = '0; wb_instr = '0; wb_data = '0; wb_rs_val = '0; wb_rt_val = '0; wb_v0_val = '0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;

      chk("rst_valid",   trace_valid,   1'b0);
      chk("rst_stall",   stall_req,     1'b0);
      chk("rst_ovf",     overflow,      1'b0);
      chk("rst_done",    test_done,     1'b0);
      chk("rst_retired", retired_count, 32'd0);
      chk("rst_pc",      trace_pc,      32'd0);

      // single R-type add
      trace_ready = 1'b1;
      wb_pulse(32'h0, 32'h0109_5020, 1'b1, 32'h5, 32'h11, 32'h22, 32'h0, 1'b1, 2'd0, 5'd10, 32'h5);
      wait_drain(10);
      chk("r_retired", retired_count, 32'd1);

      // fill to full with ready low, fifth capture dropped
      trace_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         if (i == 1)
            wb_pulse(32'h1004, 32'h2109_0002, 1'b0, 32'h201, 32'h11, 32'h77, 32'h0, 1'b1, 2'd1, 5'd9, 32'h77);
         else
            push_i(i, i < 4);
         if (i == 2) chk("stall_not_full", stall_req, 1'b0);
         if (i == 3) chk("stall_full", stall_req, 1'b1);
      end
      chk("ovf_set",      overflow,      1'b1);
      chk("ovf_retired",  retired_count, 32'd5);
      idle(2);
      chk("ovf_hold_valid", trace_valid, 1'b1);
      trace_ready = 1'b1;
      wait_drain(20);
      idle(2);
      chk("drained_valid", trace_valid, 1'b0);
      chk("drained_stall", stall_req,   1'b0);
      chk("ovf_sticky",    overflow,    1'b1);

      // push and pop together while full
      do_reset();
      chk("rst2_ovf", overflow, 1'b0);
      trace_ready = 1'b0;
      for (int i = 0; i < 4; i++) push_i(i, 1'b1);
      chk("full2_stall", stall_req, 1'b1);
      trace_ready = 1'b1;
      wb_pulse(32'h2000, 32'h2109_00aa, 1'b1, 32'h3aa, 32'h11, 32'h77, 32'h0, 1'b1, 2'd1, 5'd9, 32'h3aa);
      trace_ready = 1'b0;
      chk("pp_stall",   stall_req,     1'b1);
      chk("pp_ovf",     overflow,      1'b0);
      chk("pp_retired", retired_count, 32'd5);
      trace_ready = 1'b1;
      wait_drain(20);

      // bubble is never traced
      wb_pulse(32'h500, 32'h0, 1'b1, 32'h9, 32'h0, 32'h0, 32'h0, 1'b0, 2'd0, 5'd0, 32'h0);
      idle(2);
      chk("bubble_valid",   trace_valid,   1'b0);
      chk("bubble_retired", retired_count, 32'(exp_retired));

      // jumps, R-type without write-back, non-terminating syscall
      wb_pulse(32'h600, 32'h0c00_0010, 1'b1, 32'h8, 32'h1, 32'h2, 32'h0, 1'b1, 2'd2, 5'd31, 32'h8);
      wb_pulse(32'h604, 32'h0800_0020, 1'b0, 32'h0, 32'h1, 32'h2, 32'h0, 1'b1, 2'd2, 5'd0,  32'h0);
      wb_pulse(32'h608, 32'h0109_5020, 1'b0, 32'h0, 32'h3, 32'h4, 32'h0, 1'b1, 2'd0, 5'd10, 32'h0);
      wb_pulse(32'h700, 32'h0000_000c, 1'b0, 32'h0, 32'h1, 32'h2, 32'h1, 1'b1, 2'd3, 5'd0,  32'h0);
      wait_drain(20);
      idle(3);
      chk("sys_v0_1_done", test_done,     1'b0);
      chk("misc_retired",  retired_count, 32'(exp_retired));

      // reset mid-transfer discards queued records immediately
      trace_ready = 1'b0;
      push_i(0, 1'b1);
      push_i(1, 1'b1);
      reset = 1'b1;
      #2;
      chk("midrst_valid", trace_valid, 1'b0);
      chk("midrst_pc",    trace_pc,    32'd0);
      exp_q.delete();
      exp_retired = 0;
      @(posedge clk); #1;
      reset = 1'b0;
      chk("midrst_retired", retired_count, 32'd0);
      idle(1);
      chk("midrst_valid2", trace_valid, 1'b0);

      // end-of-test: two queued, syscall v0=0xa, later capture ignored
      push_i(0, 1'b1);
      push_i(1, 1'b1);
      wb_pulse(32'h800, 32'h0000_000c, 1'b0, 32'h0, 32'h5, 32'h6, 32'ha, 1'b1, 2'd3, 5'd0, 32'h0);
      push_i(2, 1'b0);
      chk("drain_retired", retired_count, 32'd3);
      chk("drain_done0",   test_done,     1'b0);
      trace_ready = 1'b1;
      wait_drain(20);
      w = 0;
      while (!test_done && w < 10) begin
         @(posedge clk); #1;
         w++;
      end
      chk("eot_done",  test_done,   1'b1);
      chk("eot_valid", trace_valid, 1'b0);
      push_i(3, 1'b0);
      idle(2);
      chk("done_retired", retired_count, 32'd3);
      chk("done_valid",   trace_valid,   1'b0);
      chk("done_hold",    test_done,     1'b1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
